// File: rtl/game_pkg.sv
// game_pkg
// Shared definitions for the lane-based game: wave scheduler state
// encoding, lane count, default health / kill-target constants (also used
// by the 7-segment display logic), the LFSR seed and a 12-bit mod-3 helper.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    SPAWN  = 3'd2,
    ACTIVE = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int unsigned LANE_COUNT       = 3;
  localparam int unsigned HEALTH_INIT_DEF  = 3;
  localparam int unsigned KILLS_TO_WIN_DEF = 6;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // 4 == 1 (mod 3), so summing the six base-4 digits keeps the residue and
  // shrinks the divide to a 5-bit operand (max digit sum is 18).
  function automatic logic [1:0] mod3_12(input logic [11:0] x);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < 6; i++) begin
      s = s + {3'b000, x[2*i +: 2]};
    end
    return 2'(s % 5'(LANE_COUNT));
  endfunction

endpackage

// File: rtl/lane_picker.sv
// lane_picker
// Chooses a spawn lane 0..2 from the live mic sample. The output is purely
// combinational; only the optional LFSR is registered.
//
// Build option: WAVE_SCHED_LFSR_MIX_EN
//   defined   - 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//               advances every clock and is XOR-mixed into the sample.
//   undefined - lane = mic mod 3, no flops and no clock/reset ports.
//
// Ports:
//   clock, reset  in   clock and synchronous active-high reset (LFSR build only)
//   mic_i         in   12-bit mic sample
//   lane_o        out  lane 0..2
module lane_picker
  import game_pkg::*;
(
`ifdef WAVE_SCHED_LFSR_MIX_EN
  input  logic        clock,
  input  logic        reset,
`endif
  input  logic [11:0] mic_i,
  output logic [1:0]  lane_o
);

`ifdef WAVE_SCHED_LFSR_MIX_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lane_o = mod3_12(mic_i ^ lfsr_q[11:0]);
`else
  assign lane_o = mod3_12(mic_i);
`endif

endmodule

// File: rtl/wave_scheduler.sv
// wave_scheduler
// Sequences enemy waves: waits SPAWN_INTERVAL clocks, requests a spawn on a
// picked lane, then waits for the enemy to be killed or to reach the player.
// Tracks health, kill count and enemy speed, and declares win or lose.
//
// Build option: WAVE_SCHED_LFSR_MIX_EN (LFSR mixing in lane_picker).
//
// Ports:
//   clock          in   system clock
//   reset          in   synchronous active-high reset
//   start_game     in   level, high = game running, low = abort / idle
//   mic_in         in   12-bit mic sample (lane entropy)
//   spawn_ack      in   datapath accepted the spawn
//   enemy_killed   in   pulse, current enemy killed
//   enemy_reached  in   pulse, enemy reached the player column
//   spawn_req      out  request to place an enemy
//   spawn_lane     out  lane 0..2, held after the request
//   enemy_speed    out  clocks per enemy pixel step
//   health         out  remaining lives
//   kill_count     out  kills so far
//   end_game       out  game finished
//   lose           out  qualifies end_game
//
// state  | meaning
// IDLE   | outputs at reset values, waiting for start_game
// WAIT   | counting the inter-spawn interval
// SPAWN  | spawn_req high, lane frozen, waiting for spawn_ack
// ACTIVE | enemy on the field, waiting for kill or reach
// DONE   | end_game/lose held until start_game drops
module wave_scheduler
  import game_pkg::*;
#(
  parameter int unsigned SPAWN_INTERVAL = 6250000,
  parameter int unsigned SPEED_INIT     = 400000,
  parameter int unsigned SPEED_STEP     = 50000,
  parameter int unsigned SPEED_MIN      = 100000,
  parameter int unsigned HEALTH_INIT    = HEALTH_INIT_DEF,
  parameter int unsigned KILLS_TO_WIN   = KILLS_TO_WIN_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_game,
  input  logic [11:0] mic_in,
  input  logic        spawn_ack,
  input  logic        enemy_killed,
  input  logic        enemy_reached,
  output logic        spawn_req,
  output logic [1:0]  spawn_lane,
  output logic [31:0] enemy_speed,
  output logic [3:0]  health,
  output logic [3:0]  kill_count,
  output logic        end_game,
  output logic        lose
);

  // Speed may step down only while it is at least this far above the floor;
  // 33 bits so the sum cannot wrap.
  localparam logic [32:0] DEC_FLOOR = 33'(SPEED_MIN) + 33'(SPEED_STEP);

  state_e      state_q,     state_d;
  logic [31:0] cnt_q,       cnt_d;
  logic        spawn_req_q, spawn_req_d;
  logic [1:0]  lane_q,      lane_d;
  logic [31:0] speed_q,     speed_d;
  logic [3:0]  health_q,    health_d;
  logic [3:0]  kills_q,     kills_d;
  logic        end_q,       end_d;
  logic        lose_q,      lose_d;

  logic [1:0]  lane_pick;
  logic [31:0] speed_dec;
  logic [3:0]  kills_inc;
  logic [3:0]  health_dec;
  logic        go_idle;

  lane_picker u_lane_picker (
`ifdef WAVE_SCHED_LFSR_MIX_EN
    .clock  (clock),
    .reset  (reset),
`endif
    .mic_i  (mic_in),
    .lane_o (lane_pick)
  );

  assign speed_dec  = ({1'b0, speed_q} >= DEC_FLOOR) ? (speed_q - 32'(SPEED_STEP))
                                                     : 32'(SPEED_MIN);
  assign kills_inc  = kills_q + 4'd1;
  assign health_dec = health_q - 4'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    spawn_req_d = spawn_req_q;
    lane_d      = lane_q;
    speed_d     = speed_q;
    health_d    = health_q;
    kills_d     = kills_q;
    end_d       = end_q;
    lose_d      = lose_q;
    go_idle     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_game) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end

      WAIT: begin
        if (!start_game) begin
          go_idle = 1'b1;
        end else if (cnt_q == 32'(SPAWN_INTERVAL - 1)) begin
          state_d     = SPAWN;
          lane_d      = lane_pick;
          spawn_req_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      SPAWN: begin
        if (!start_game) begin
          go_idle = 1'b1;
        end else if (spawn_ack) begin
          state_d     = ACTIVE;
          spawn_req_d = 1'b0;
        end
      end

      ACTIVE: begin
        if (!start_game) begin
          go_idle = 1'b1;
        end else if (enemy_killed) begin
          // A simultaneous reach is dropped: the kill takes priority.
          kills_d = kills_inc;
          speed_d = speed_dec;
          if (kills_inc == 4'(KILLS_TO_WIN)) begin
            state_d = DONE;
            end_d   = 1'b1;
            lose_d  = 1'b0;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end else if (enemy_reached && (health_q != 4'd0)) begin
          health_d = health_dec;
          if (health_dec == 4'd0) begin
            state_d = DONE;
            end_d   = 1'b1;
            lose_d  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end

      DONE: begin
        if (!start_game) begin
          go_idle = 1'b1;
        end
      end

      default: begin
        go_idle = 1'b1;
      end
    endcase

    // Leaving the game by any route restores every output to its reset value.
    if (go_idle) begin
      state_d     = IDLE;
      cnt_d       = '0;
      spawn_req_d = 1'b0;
      lane_d      = '0;
      speed_d     = 32'(SPEED_INIT);
      health_d    = 4'(HEALTH_INIT);
      kills_d     = '0;
      end_d       = 1'b0;
      lose_d      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      spawn_req_q <= 1'b0;
      lane_q      <= '0;
      speed_q     <= 32'(SPEED_INIT);
      health_q    <= 4'(HEALTH_INIT);
      kills_q     <= '0;
      end_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      spawn_req_q <= spawn_req_d;
      lane_q      <= lane_d;
      speed_q     <= speed_d;
      health_q    <= health_d;
      kills_q     <= kills_d;
      end_q       <= end_d;
      lose_q      <= lose_d;
    end
  end

  assign spawn_req   = spawn_req_q;
  assign spawn_lane  = lane_q;
  assign enemy_speed = speed_q;
  assign health      = health_q;
  assign kill_count  = kills_q;
  assign end_game    = end_q;
  assign lose        = lose_q;

endmodule

// File: tb/tb_wave_scheduler.sv
// tb_wave_scheduler
// Self-checking bench for wave_scheduler with a short spawn interval.
// Inputs are driven and outputs sampled on the falling clock edge. The
// reference model tracks lives, kills and speed as plain integers and
// derives the expected lane directly as mic % 3.
module tb_wave_scheduler;

  localparam int SI     = 10;
  localparam int S_INIT = 400000;
  localparam int S_STEP = 50000;
  localparam int S_MIN  = 100000;
  localparam int H_INIT = 3;
  localparam int K_WIN  = 6;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_game;
  logic [11:0] mic_in;
  logic        spawn_ack;
  logic        enemy_killed;
  logic        enemy_reached;
  logic        spawn_req;
  logic [1:0]  spawn_lane;
  logic [31:0] enemy_speed;
  logic [3:0]  health;
  logic [3:0]  kill_count;
  logic        end_game;
  logic        lose;

  int errors = 0;
  int checks = 0;

  int m_health;
  int m_kills;
  int m_speed;

  always #5 clock = ~clock;

  wave_scheduler #(
    .SPAWN_INTERVAL (SI),
    .SPEED_INIT     (S_INIT),
    .SPEED_STEP     (S_STEP),
    .SPEED_MIN      (S_MIN),
    .HEALTH_INIT    (H_INIT),
    .KILLS_TO_WIN   (K_WIN)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_game    (start_game),
    .mic_in        (mic_in),
    .spawn_ack     (spawn_ack),
    .enemy_killed  (enemy_killed),
    .enemy_reached (enemy_reached),
    .spawn_req     (spawn_req),
    .spawn_lane    (spawn_lane),
    .enemy_speed   (enemy_speed),
    .health        (health),
    .kill_count    (kill_count),
    .end_game      (end_game),
    .lose          (lose)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_health = H_INIT;
    m_kills  = 0;
    m_speed  = S_INIT;
  endtask

  task automatic clear_pulses();
    spawn_ack     = 1'b0;
    enemy_killed  = 1'b0;
    enemy_reached = 1'b0;
  endtask

  // Counts falling edges until spawn_req is seen; 9999 on timeout.
  task automatic wait_spawn(output int n);
    n = 0;
    while (spawn_req !== 1'b1 && n < 200) begin
      @(negedge clock);
      clear_pulses();
      n++;
    end
    if (spawn_req !== 1'b1) n = 9999;
  endtask

  task automatic ack_spawn();
    spawn_ack = 1'b1;
    @(negedge clock);
    spawn_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    start_game = 1'b1;
    mic_in     = 12'd0;
    clear_pulses();
    repeat (4) @(negedge clock);
    model_reset();
    checks++; if (spawn_req !== 1'b0) begin errors++; $display("FAIL reset_spawn_req: got %0d expected 0", spawn_req); end
    checks++; if (spawn_lane !== 2'd0) begin errors++; $display("FAIL reset_lane: got %0d expected 0", spawn_lane); end
    checks++; if (enemy_speed !== 32'(S_INIT)) begin errors++; $display("FAIL reset_speed: got %0d expected %0d", enemy_speed, S_INIT); end
    checks++; if (health !== 4'(H_INIT)) begin errors++; $display("FAIL reset_health: got %0d expected %0d", health, H_INIT); end
    checks++; if (kill_count !== 4'd0) begin errors++; $display("FAIL reset_kills: got %0d expected 0", kill_count); end
    checks++; if (end_game !== 1'b0 || lose !== 1'b0) begin errors++; $display("FAIL reset_end: got end=%0d lose=%0d expected 0/0", end_game, lose); end
    start_game = 1'b0;
    reset      = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_kill_win();
    int          n;
    int          dly;
    logic [11:0] mic;
    logic [1:0]  exp_lane;
    model_reset();
    mic        = 12'd7;
    mic_in     = mic;
    start_game = 1'b1;
    wait_spawn(n);
    checks++; if (n != SI + 1) begin errors++; $display("FAIL first_spawn_latency: got %0d expected %0d", n, SI + 1); end
    for (int k = 1; k <= K_WIN; k++) begin
      exp_lane = 2'(int'(mic) % 3);
      checks++; if (spawn_lane !== exp_lane) begin errors++; $display("FAIL lane_wave%0d: got %0d expected %0d (mic=%0d)", k, spawn_lane, exp_lane, mic); end
      dly = (k == 1) ? 0 : int'($urandom_range(0, 4));
      repeat (dly) begin
        @(negedge clock);
        mic_in = 12'($urandom);
      end
      checks++; if (spawn_req !== 1'b1 || spawn_lane !== exp_lane) begin errors++; $display("FAIL spawn_hold_wave%0d: got req=%0d lane=%0d expected 1/%0d", k, spawn_req, spawn_lane, exp_lane); end
      ack_spawn();
      checks++; if (spawn_req !== 1'b0) begin errors++; $display("FAIL ack_drop_wave%0d: got %0d expected 0", k, spawn_req); end
      repeat ($urandom_range(0, 4)) @(negedge clock);
      mic           = 12'($urandom);
      mic_in        = mic;
      enemy_killed  = 1'b1;
      @(negedge clock);
      enemy_killed  = 1'b0;
      m_kills++;
      m_speed = (m_speed - S_STEP < S_MIN) ? S_MIN : m_speed - S_STEP;
      checks++; if (kill_count !== 4'(m_kills)) begin errors++; $display("FAIL kills_wave%0d: got %0d expected %0d", k, kill_count, m_kills); end
      checks++; if (enemy_speed !== 32'(m_speed)) begin errors++; $display("FAIL speed_wave%0d: got %0d expected %0d", k, enemy_speed, m_speed); end
      checks++; if (end_game !== 1'(m_kills == K_WIN) || lose !== 1'b0) begin errors++; $display("FAIL end_wave%0d: got end=%0d lose=%0d expected %0d/0", k, end_game, lose, m_kills == K_WIN); end
      if (k < K_WIN) begin
        wait_spawn(n);
        checks++; if (n != SI) begin errors++; $display("FAIL respawn_latency_wave%0d: got %0d expected %0d", k, n + 1, SI + 1); end
      end
    end
    repeat (5) @(negedge clock);
    enemy_killed = 1'b1;
    @(negedge clock);
    enemy_killed = 1'b0;
    checks++; if (kill_count !== 4'(K_WIN) || end_game !== 1'b1 || lose !== 1'b0) begin errors++; $display("FAIL done_hold_win: got kills=%0d end=%0d lose=%0d expected %0d/1/0", kill_count, end_game, lose, K_WIN); end
    start_game = 1'b0;
    @(negedge clock);
    checks++; if (end_game !== 1'b0 || kill_count !== 4'd0 || enemy_speed !== 32'(S_INIT)) begin errors++; $display("FAIL done_exit: got end=%0d kills=%0d speed=%0d expected 0/0/%0d", end_game, kill_count, enemy_speed, S_INIT); end
  endtask

  task automatic test_lose();
    int n;
    model_reset();
    mic_in     = 12'($urandom);
    start_game = 1'b1;
    for (int k = 1; k <= H_INIT; k++) begin
      wait_spawn(n);
      ack_spawn();
      repeat ($urandom_range(0, 3)) @(negedge clock);
      enemy_reached = 1'b1;
      @(negedge clock);
      enemy_reached = 1'b0;
      m_health--;
      checks++; if (health !== 4'(m_health)) begin errors++; $display("FAIL health_hit%0d: got %0d expected %0d", k, health, m_health); end
      checks++; if (end_game !== 1'(m_health == 0) || lose !== 1'(m_health == 0)) begin errors++; $display("FAIL lose_hit%0d: got end=%0d lose=%0d expected %0d", k, end_game, lose, m_health == 0); end
    end
    enemy_reached = 1'b1;
    @(negedge clock);
    enemy_reached = 1'b0;
    @(negedge clock);
    checks++; if (health !== 4'd0 || end_game !== 1'b1 || lose !== 1'b1) begin errors++; $display("FAIL done_hold_lose: got health=%0d end=%0d lose=%0d expected 0/1/1", health, end_game, lose); end
    start_game = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_both_and_ignored();
    int n;
    model_reset();
    mic_in     = 12'($urandom);
    start_game = 1'b1;
    wait_spawn(n);
    ack_spawn();
    enemy_killed  = 1'b1;
    enemy_reached = 1'b1;
    @(negedge clock);
    clear_pulses();
    checks++; if (kill_count !== 4'd1 || health !== 4'(H_INIT) || enemy_speed !== 32'(S_INIT - S_STEP)) begin errors++; $display("FAIL both_events: got kills=%0d health=%0d speed=%0d expected 1/%0d/%0d", kill_count, health, enemy_speed, H_INIT, S_INIT - S_STEP); end
    repeat (2) @(negedge clock);
    enemy_killed  = 1'b1;
    enemy_reached = 1'b1;
    @(negedge clock);
    clear_pulses();
    checks++; if (kill_count !== 4'd1 || health !== 4'(H_INIT)) begin errors++; $display("FAIL wait_events_ignored: got kills=%0d health=%0d expected 1/%0d", kill_count, health, H_INIT); end
    wait_spawn(n);
    enemy_killed = 1'b1;
    @(negedge clock);
    enemy_killed = 1'b0;
    checks++; if (kill_count !== 4'd1 || spawn_req !== 1'b1) begin errors++; $display("FAIL spawn_kill_ignored: got kills=%0d req=%0d expected 1/1", kill_count, spawn_req); end
  endtask

  // Continues from SPAWN left by the previous scenario.
  task automatic test_stall_abort();
    int         n;
    int         bad;
    logic [1:0] held;
    held = spawn_lane;
    bad  = 0;
    for (int i = 0; i < 100; i++) begin
      mic_in = 12'($urandom);
      @(negedge clock);
      if (spawn_req !== 1'b1 || spawn_lane !== held) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad); end
    start_game = 1'b0;
    spawn_ack  = 1'b1;
    @(negedge clock);
    clear_pulses();
    checks++; if (spawn_req !== 1'b0 || spawn_lane !== 2'd0) begin errors++; $display("FAIL abort_req: got req=%0d lane=%0d expected 0/0", spawn_req, spawn_lane); end
    checks++; if (health !== 4'(H_INIT) || kill_count !== 4'd0 || enemy_speed !== 32'(S_INIT)) begin errors++; $display("FAIL abort_reload: got health=%0d kills=%0d speed=%0d expected %0d/0/%0d", health, kill_count, enemy_speed, H_INIT, S_INIT); end
    enemy_killed = 1'b1;
    @(negedge clock);
    enemy_killed = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (kill_count !== 4'd0 || spawn_req !== 1'b0) begin errors++; $display("FAIL idle_ignored: got kills=%0d req=%0d expected 0/0", kill_count, spawn_req); end
    mic_in     = 12'd2;
    start_game = 1'b1;
    wait_spawn(n);
    checks++; if (n != SI + 1 || spawn_lane !== 2'd2) begin errors++; $display("FAIL restart_spawn: got latency=%0d lane=%0d expected %0d/2", n, spawn_lane, SI + 1); end
    ack_spawn();
    start_game = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_kill_win();
    test_lose();
    test_both_and_ignored();
    test_stall_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_scheduler.md
# wave_scheduler

Sequences enemy waves for the lane-based player-vs-monsters game. It decides when an enemy spawns, which of the three lanes it uses, and how fast it moves. It also tracks health and kill count and declares win or lose. It sits between the top-level game-mode FSM (`start_game`) and the rendering/collision datapath, which consumes `spawn_req`/`spawn_lane`/`enemy_speed` and reports `enemy_killed`/`enemy_reached`.

## Interface
Parameters:
- `SPAWN_INTERVAL`, 6250000 — clocks between the end of one enemy's life and the next spawn request (1 s at 6.25 MHz).
- `SPEED_INIT`, 400000 — initial clocks per enemy 1-pixel step.
- `SPEED_STEP`, 50000 — decrement of `enemy_speed` per kill.
- `SPEED_MIN`, 100000 — floor for `enemy_speed`.
- `HEALTH_INIT`, 3 — starting lives, 1..15.
- `KILLS_TO_WIN`, 6 — kills that end the game as a win, 1..15.

Ports:
- `clock`  in  1  — system clock. One clock only; reset is synchronous and active-high.
- `reset`  in  1  — synchronous, active-high.
- `start_game`  in  1  — level; high = game running, low = abort/idle.
- `mic_in`  in  12  — live mic sample, used as the entropy source.
- `spawn_ack`  in  1  — datapath accepted the spawn (pulse).
- `enemy_killed`  in  1  — 1-cycle pulse: the attack killed the current enemy.
- `enemy_reached`  in  1  — 1-cycle pulse: the enemy reached the player column.
- `spawn_req`  out  1  — request to place an enemy.
- `spawn_lane`  out  2  — lane 0..2; valid while `spawn_req` is high, held afterwards.
- `enemy_speed`  out  32  — current clocks-per-step.
- `health`  out  4 — remaining lives.
- `kill_count`  out  4 — kills so far.
- `end_game`  out  1 — game finished.
- `lose`  out  1 — qualifies `end_game`.

## Operation
- Reset values:
  - `spawn_req`=0, `spawn_lane`=0, `enemy_speed`=SPEED_INIT, `health`=HEALTH_INIT, `kill_count`=0, `end_game`=0, `lose`=0.
  - State IDLE, interval counter 0.
- FSM states: IDLE, WAIT, SPAWN, ACTIVE, DONE.
- IDLE:
  - Outputs are held at reset values.
  - `start_game`=1 → WAIT, interval counter cleared.
- WAIT:
  - Counter increments each clock.
  - At count SPAWN_INTERVAL-1, the lane is latched from the lane picker → SPAWN.
- SPAWN:
  - `spawn_req`=1 and `spawn_lane` is stable until `spawn_ack`.
  - On `spawn_ack` → ACTIVE, `spawn_req`=0.
  - There is no timeout.
- ACTIVE waits for an event:
  - `enemy_killed`:
    - `kill_count`+1.
    - `enemy_speed` = max(`enemy_speed`−SPEED_STEP, SPEED_MIN), computed without underflow.
    - If the new count equals KILLS_TO_WIN → DONE with `lose`=0; else → WAIT.
  - `enemy_reached`:
    - `health`−1.
    - If the new health is 0 → DONE with `lose`=1; else → WAIT.
  - Both in the same cycle: kill wins, and `enemy_reached` is dropped.
- DONE: `end_game`=1 and `lose` are held until `start_game`=0 → IDLE.
- `start_game`=0 in WAIT, SPAWN or ACTIVE → IDLE next clock:
  - All counters reload and `spawn_req` drops.
  - A pending `spawn_ack` is ignored.
- `enemy_killed`/`enemy_reached` outside ACTIVE are ignored.
- `spawn_ack` outside SPAWN is ignored.
- `health` never wraps below 0. `kill_count` never exceeds KILLS_TO_WIN.

## Timing
- Kill or hit event in ACTIVE → counters update on the next edge. The FSM is in WAIT (or DONE) that same edge.
- Event to next `spawn_req` rise: exactly SPAWN_INTERVAL+1 clocks.
- IDLE→WAIT: 1 clock after `start_game` rises. The first `spawn_req` rises SPAWN_INTERVAL+1 clocks later.
- `spawn_ack` in the same cycle `spawn_req` first rises is accepted: ACTIVE on the next edge.
- `end_game` rises the clock after the deciding event.
- `reset` overrides everything, including a `start_game`=1 input.

## Configuration
- `WAVE_SCHED_LFSR_MIX_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every clock.
  - Lane = (`mic_in` ^ lfsr[11:0]) mod 3.
- `WAVE_SCHED_LFSR_MIX_EN` undefined:
  - Lane = `mic_in` mod 3.
  - No LFSR flops are built.

## Structure
- Shared package `game_pkg` holds:
  - the state enum (IDLE/WAIT/SPAWN/ACTIVE/DONE);
  - `LANE_COUNT`=3;
  - the default HEALTH_INIT/KILLS_TO_WIN constants, shared with the 7-segment display logic.
- One sub-module, `lane_picker`, holds the optional LFSR plus the 12-bit mod-3 reduction. It is combinational output with registered LFSR.

## Test plan
- Reset, then `start_game`=1 with SPAWN_INTERVAL=10 → `spawn_req` rises 11 clocks later. With `mic_in`=12'd7 (LFSR off), `spawn_lane`=1.
- Kill six enemies with SPEED_INIT=400000 → `enemy_speed` steps 350000…100000 and then holds at 100000. After the 6th kill, `end_game`=1 and `lose`=0 one clock later.
- Three `enemy_reached` pulses → `health` 3→2→1→0, with `end_game`=1 and `lose`=1 after the third. A fourth pulse in DONE leaves `health` at 0.
- `enemy_killed` and `enemy_reached` in the same ACTIVE cycle → `kill_count`+1 and `health` unchanged.
- Hold `spawn_ack`=0 for 100 clocks in SPAWN → `spawn_req` stays high and `spawn_lane` stays constant while `mic_in` varies.
- Drop `start_game` mid-SPAWN → next clock: IDLE, `spawn_req`=0, `health`=3, `kill_count`=0, `enemy_speed`=SPEED_INIT.
